// File: rtl/game_pkg.sv
// Shared game types and LFSR helpers for the obstacle_field core.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int              LFSR_W    = 9;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 9'b100010000;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1FF;

    // Fibonacci step: XOR of the tapped bits shifts in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_rotl(input logic [LFSR_W-1:0] v,
                                                     input int unsigned       sh);
        logic [2*LFSR_W-1:0] dbl;
        dbl = {v, v} << (sh % LFSR_W);
        return dbl[2*LFSR_W-1 -: LFSR_W];
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One falling obstacle: position registers, per-frame motion and respawn to a random column.
module obstacle_slot #(
    parameter int CORDW    = 16,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0,
    parameter int SPAWN_Y  = -300,
    parameter int GROUND_Y = 230
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    reload_i,
    input  logic                    move_i,
    input  logic signed [CORDW-1:0] speed_i,
    input  logic        [CORDW-1:0] rnd_i,
    output logic        [CORDW-1:0] x_o,
    output logic        [CORDW-1:0] y_o,
    output logic                    respawn_o
);

    localparam logic signed [CORDW-1:0] X_RST   = CORDW'(X_INIT);
    localparam logic signed [CORDW-1:0] Y_RST   = CORDW'(Y_INIT);
    localparam logic signed [CORDW-1:0] Y_SPAWN = CORDW'(SPAWN_Y);
    localparam logic signed [CORDW-1:0] Y_FLOOR = CORDW'(GROUND_Y);

    logic signed [CORDW-1:0] x_q, x_d;
    logic signed [CORDW-1:0] y_q, y_d;
    logic                    below_ground;

    // Both operands signed: obstacles start far above the screen at negative y.
    assign below_ground = (y_q > Y_FLOOR);
    assign respawn_o    = move_i && below_ground;

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (reload_i) begin
            x_d = X_RST;
            y_d = Y_RST;
        end else if (move_i) begin
            if (below_ground) begin
                x_d = $signed(rnd_i);
                y_d = Y_SPAWN;
            end else begin
                y_d = y_q + speed_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            x_q <= X_RST;
            y_q <= Y_RST;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/obstacle_field.sv
// Game core for N falling obstacles: FSM, LFSR respawn columns, collision and score.
// Optional feature: define DIFFICULTY_EN for score-driven speed levels.
module obstacle_field
    import game_pkg::*;
#(
    parameter int CORDW        = 16,
    parameter int N_OBJ        = 5,
    parameter int X0           = 158,
    parameter int X_STEP       = 64,
    parameter int SPAWN_Y      = -300,
    parameter int Y_STEP       = 50,
    parameter int GROUND_Y     = 230,
    parameter int FALL_SPX     = 1,
    parameter int MAX_SPX      = 4,
    parameter int LEVEL_STEP   = 10,
    parameter int SCOREW       = 8,
    parameter int DYING_FRAMES = 120
) (
    input  logic                     clk_pix,
    input  logic                     rst_pix_n,
    input  logic                     frame,
    input  logic                     de,
    input  logic                     start,
    input  logic                     player_draw,
    input  logic [N_OBJ-1:0]         obj_draw,
    output logic [N_OBJ*CORDW-1:0]   obj_x,
    output logic [N_OBJ*CORDW-1:0]   obj_y,
    output logic [SCOREW-1:0]        score,
    output logic [2:0]               level,
    output logic                     dead,
    output game_state_t              state
);

    localparam int SCORE_MAX = (1 << SCOREW) - 1;
    localparam int DCW       = $clog2(DYING_FRAMES + 1);

    if (N_OBJ < 1 || N_OBJ > 16 || LEVEL_STEP < 1 || MAX_SPX < FALL_SPX
        || DYING_FRAMES < 1) begin : g_bad_cfg
        $error("obstacle_field: illegal parameter combination");
    end

    game_state_t             state_q, state_d;
    logic [LFSR_W-1:0]       lfsr_q;
    logic                    start_q;
    logic [SCOREW-1:0]       score_q, score_d;
    logic                    dead_q, dead_d;
    logic [DCW-1:0]          dying_cnt_q, dying_cnt_d;
    logic [N_OBJ-1:0]        respawn;
    logic signed [CORDW-1:0] speed;
    logic                    collide, start_rise;
    logic                    move_en, reload_en, hit_en, dying_tick;
    int                      pop_cnt, score_sum;

    assign collide    = de && player_draw && (|obj_draw);
    assign start_rise = start && !start_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)      state_d = PLAY;
            PLAY:  if (collide)    state_d = DYING;
            DYING: if (frame && dying_cnt_q == DCW'(DYING_FRAMES - 1))
                                   state_d = OVER;
            OVER:  if (start_rise) state_d = PLAY;
            default:               state_d = IDLE;
        endcase
    end

    // A collision in the same cycle as a frame pulse suppresses that frame's motion.
    always_comb begin
        move_en    = (state_q == PLAY) && frame && !collide;
        hit_en     = (state_q == PLAY) && collide;
        dying_tick = (state_q == DYING) && frame;
        reload_en  = (state_q == OVER) && start_rise;
    end

    // ---------------- obstacles ----------------
    for (genvar i = 0; i < N_OBJ; i++) begin : g_slot
        logic [CORDW-1:0] rnd;
        assign rnd = CORDW'(lfsr_rotl(lfsr_q, (3 * i) % LFSR_W));

        obstacle_slot #(
            .CORDW    (CORDW),
            .X_INIT   (X0 + i * X_STEP),
            .Y_INIT   (SPAWN_Y - i * Y_STEP),
            .SPAWN_Y  (SPAWN_Y),
            .GROUND_Y (GROUND_Y)
        ) u_slot (
            .clk_pix   (clk_pix),
            .rst_pix_n (rst_pix_n),
            .reload_i  (reload_en),
            .move_i    (move_en),
            .speed_i   (speed),
            .rnd_i     (rnd),
            .x_o       (obj_x[i*CORDW +: CORDW]),
            .y_o       (obj_y[i*CORDW +: CORDW]),
            .respawn_o (respawn[i])
        );
    end

    // ---------------- score, death, dying timer ----------------
    always_comb begin
        pop_cnt = 0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (respawn[i]) pop_cnt++;
        end
        score_sum = int'(score_q) + pop_cnt;
    end

    always_comb begin
        score_d     = score_q;
        dead_d      = dead_q;
        dying_cnt_d = dying_cnt_q;
        if (reload_en) begin
            score_d = '0;
            dead_d  = 1'b0;
        end else if (move_en) begin
            score_d = (score_sum > SCORE_MAX) ? SCOREW'(SCORE_MAX) : SCOREW'(score_sum);
        end
        if (hit_en) begin
            dead_d      = 1'b1;
            dying_cnt_d = '0;
        end else if (dying_tick) begin
            dying_cnt_d = dying_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            lfsr_q      <= LFSR_SEED;
            start_q     <= 1'b0;
            score_q     <= '0;
            dead_q      <= 1'b0;
            dying_cnt_q <= '0;
        end else begin
            lfsr_q      <= lfsr_next(lfsr_q);
            start_q     <= start;
            score_q     <= score_d;
            dead_q      <= dead_d;
            dying_cnt_q <= dying_cnt_d;
        end
    end

    // ---------------- speed levels ----------------
`ifdef DIFFICULTY_EN
    localparam int PTW = $clog2(LEVEL_STEP + N_OBJ + 1);

    logic [2:0]     level_q, level_d;
    logic [PTW-1:0] pts_q, pts_d;
    int             pts_sum, speed_sum;

    // Points carry across level boundaries so no score is lost between levels.
    always_comb begin
        level_d   = level_q;
        pts_d     = pts_q;
        pts_sum   = int'(pts_q) + pop_cnt;
        speed_sum = FALL_SPX + int'(level_q);
        if (reload_en) begin
            level_d = '0;
            pts_d   = '0;
        end else if (move_en) begin
            if (pts_sum >= LEVEL_STEP) begin
                pts_d = PTW'(pts_sum - LEVEL_STEP);
                if (level_q != 3'd7) level_d = level_q + 3'd1;
            end else begin
                pts_d = PTW'(pts_sum);
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            level_q <= '0;
            pts_q   <= '0;
        end else begin
            level_q <= level_d;
            pts_q   <= pts_d;
        end
    end

    assign speed = CORDW'((speed_sum > MAX_SPX) ? MAX_SPX : speed_sum);
    assign level = level_q;
`else
    assign speed = CORDW'(FALL_SPX);
    assign level = 3'd0;
`endif

    assign score = score_q;
    assign dead  = dead_q;
    assign state = state_q;

endmodule
